// File: rtl/uart_crc_frame_rx.sv
// uart_crc_frame_rx: assembles SOF/LEN/payload/CRC-8 frames from UART bytes and drains good payloads
// Optional inter-byte timeout: define UART_CRC_RX_TIMEOUT_EN
module uart_crc_frame_rx #(
    parameter int MAX_LEN     = 16,
    parameter logic [7:0] SOF_BYTE = 8'h7E,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       pl_valid_o,
    output logic [7:0] pl_data_o,
    output logic       pl_last_o,
    input  logic       pl_ready_i,
    output logic       frame_ok_o,
    output logic       crc_err_o,
    output logic       len_err_o,
    output logic       ovf_err_o,
    output logic       tmo_err_o,
    output logic       busy_o
);
    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam logic [7:0] MAXB = 8'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CRC, DRAIN} state_t;

    state_t        state, state_n;
    logic [7:0]    crc, crc_n;
    logic [IW-1:0] len, len_n, idx, idx_n, rd, rd_n;
    logic          wr, ok_n, cerr_n, lerr_n, ovf_n, tmo_n, tmo_hit;
    logic [7:0]    mem [MAX_LEN];

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
        return x;
    endfunction

`ifdef UART_CRC_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] gap;
    logic          in_frame;
    assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CRC);
    assign tmo_hit  = in_frame && (gap == TW'(TIMEOUT_CYC - 1));
    // gap counter: cycles since the last byte while a frame is open
    always_ff @(posedge clk or negedge rst_i)
        if (!rst_i) gap <= '0;
        else gap <= (rx_valid_i || !in_frame || tmo_hit) ? '0 : gap + 1'b1;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
    assign tmo_hit    = 1'b0;
`endif

    assign busy_o     = state != IDLE;
    assign pl_valid_o = state == DRAIN;
    assign pl_data_o  = (state == DRAIN) ? mem[rd[AW-1:0]] : 8'h00;
    assign pl_last_o  = (state == DRAIN) && (rd == len - 1'b1);

    // next-state, datapath updates and error pulse requests
    always_comb begin
        state_n = state;
        crc_n   = crc;
        len_n   = len;
        idx_n   = idx;
        rd_n    = rd;
        wr      = 1'b0;
        ok_n    = 1'b0;
        cerr_n  = 1'b0;
        lerr_n  = 1'b0;
        ovf_n   = 1'b0;
        tmo_n   = 1'b0;
        if (tmo_hit) begin
            tmo_n   = 1'b1;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (rx_valid_i && rx_data_i == SOF_BYTE) begin
                    crc_n   = 8'h00;
                    state_n = LEN;
                end
                LEN: if (rx_valid_i) begin
                    if (rx_data_i == 8'h00 || rx_data_i > MAXB) begin
                        lerr_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        len_n   = rx_data_i[IW-1:0];
                        crc_n   = crc_step(8'h00, rx_data_i);
                        idx_n   = '0;
                        state_n = PAYLOAD;
                    end
                end
                PAYLOAD: if (rx_valid_i) begin
                    wr    = 1'b1;
                    crc_n = crc_step(crc, rx_data_i);
                    idx_n = idx + 1'b1;
                    if (idx_n == len) state_n = CRC;
                end
                CRC: if (rx_valid_i) begin
                    ok_n    = rx_data_i == crc;
                    cerr_n  = rx_data_i != crc;
                    rd_n    = '0;
                    state_n = (rx_data_i == crc) ? DRAIN : IDLE;
                end
                DRAIN: begin
                    ovf_n = rx_valid_i;
                    if (pl_ready_i) begin
                        rd_n = rd + 1'b1;
                        if (rd == len - 1'b1) state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // state, counters, CRC and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_i)
        if (!rst_i) begin
            state      <= IDLE;
            crc        <= 8'h00;
            len        <= '0;
            idx        <= '0;
            rd         <= '0;
            frame_ok_o <= 1'b0;
            crc_err_o  <= 1'b0;
            len_err_o  <= 1'b0;
            ovf_err_o  <= 1'b0;
            tmo_err_o  <= 1'b0;
        end else begin
            state      <= state_n;
            crc        <= crc_n;
            len        <= len_n;
            idx        <= idx_n;
            rd         <= rd_n;
            frame_ok_o <= ok_n;
            crc_err_o  <= cerr_n;
            len_err_o  <= lerr_n;
            ovf_err_o  <= ovf_n;
            tmo_err_o  <= tmo_n;
        end

    // payload buffer write port
    always_ff @(posedge clk)
        if (wr) mem[idx[AW-1:0]] <= rx_data_i;
endmodule
